// File: rtl/axi_counter_poller.sv
// AXI4-lite read initiator: samples a 64-bit counter responder on trig or periodic tick.
// Latency: trig at edge T -> arvalid from T+2; R handshake at edge R -> smp_valid from R+1.
// Backpressure: arvalid held until arready; smp_valid held until smp_ready; one queued request, extras dropped with overrun.
// Optional build macro AXI_COUNTER_POLLER_DELTA_EN adds smp_delta (difference to previous sample).
module axi_counter_poller #(
  parameter logic [11:0] RD_ADDR  = 12'h000,
  parameter logic [2:0]  RD_PROT  = 3'b000,
  parameter int          PERIOD_W = 32
) (
  input  logic                clk_dst,
  input  logic                aresetn,
  input  logic [PERIOD_W-1:0] period,
  input  logic                trig,
  output logic                busy,
  output logic                overrun,
  output logic                arvalid,
  input  logic                arready,
  output logic [11:0]         araddr,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [1:0]          rresp,
  input  logic [63:0]         rdata,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [63:0]         smp_data,
  output logic                smp_err
`ifdef AXI_COUNTER_POLLER_DELTA_EN
  ,
  output logic [63:0]         smp_delta
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_nxt;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic                r_pending;
  logic                r_overrun;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_smp_valid;
  logic [63:0]         r_smp_data;
  logic                r_smp_err;
  logic                w_tick;
  logic                w_req;
  logic                w_enter_addr;
  logic                w_capture;

  // A zero period disables the tick; comparing with >= makes a lowered period tick at once.
  assign w_tick       = (period != '0) && (r_tick_cnt >= (period - PERIOD_W'(1)));
  assign w_req        = trig | w_tick;
  assign w_enter_addr = (w_nxt == S_ADDR) && (r_state != S_ADDR);
  assign w_capture    = (r_state == S_DATA) && rvalid;

  // Free-running tick counter, reloaded on each tick and parked at 0 while disabled.
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_tick_cnt <= '0;
    end else if ((period == '0) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + PERIOD_W'(1);
    end
  end

  // Single-entry request queue; a request seen while it is full is dropped and flagged.
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_req & r_pending;
      if (w_enter_addr) begin
        r_pending <= 1'b0;
      end else if (w_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Next-state decode for the IDLE/ADDR/DATA/HOLD read sequencer.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_pending) w_nxt = S_ADDR;
      S_ADDR:  if (arready)   w_nxt = S_DATA;
      S_DATA:  if (rvalid)    w_nxt = S_HOLD;
      S_HOLD:  if (smp_ready) w_nxt = r_pending ? S_ADDR : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State and handshake outputs registered together so they change on the same edge.
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_smp_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_arvalid   <= (w_nxt == S_ADDR);
      r_rready    <= (w_nxt == S_DATA);
      r_smp_valid <= (w_nxt == S_HOLD);
    end
  end

  // Capture the read beat; held stable through HOLD because capture only happens in DATA.
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_smp_data <= '0;
      r_smp_err  <= 1'b0;
    end else if (w_capture) begin
      r_smp_data <= rdata;
      r_smp_err  <= (rresp != 2'b00);
    end
  end

`ifdef AXI_COUNTER_POLLER_DELTA_EN
  logic [63:0] r_prev;
  logic        r_first;
  logic [63:0] r_delta;

  // Difference to the previous sample, wrapping mod 2^64; the first sample after reset reports 0.
  always_ff @(posedge clk_dst) begin
    if (!aresetn) begin
      r_prev  <= '0;
      r_first <= 1'b1;
      r_delta <= '0;
    end else if (w_capture) begin
      r_prev  <= rdata;
      r_first <= 1'b0;
      r_delta <= r_first ? 64'd0 : (rdata - r_prev);
    end
  end

  assign smp_delta = r_delta;
`endif

  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign arvalid   = r_arvalid;
  assign araddr    = RD_ADDR;
  assign arprot    = RD_PROT;
  assign rready    = r_rready;
  assign smp_valid = r_smp_valid;
  assign smp_data  = r_smp_data;
  assign smp_err   = r_smp_err;

endmodule

// File: tb/tb_axi_counter_poller.sv
// Directed bench for axi_counter_poller with a behavioural AXI-lite counter responder.
module tb_axi_counter_poller;
  localparam logic [11:0] P_ADDR = 12'h7A0;
  localparam logic [2:0]  P_PROT = 3'b010;

  logic        clk_dst = 1'b0;
  logic        aresetn;
  logic [31:0] period;
  logic        trig;
  logic        busy, overrun, arvalid, arready, rvalid, rready;
  logic [11:0] araddr;
  logic [2:0]  arprot;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        smp_valid, smp_ready, smp_err;
  logic [63:0] smp_data;
`ifdef AXI_COUNTER_POLLER_DELTA_EN
  logic [63:0] smp_delta;
`endif

  always #5 clk_dst = ~clk_dst;

  axi_counter_poller #(.RD_ADDR(P_ADDR), .RD_PROT(P_PROT), .PERIOD_W(32)) dut (
    .clk_dst(clk_dst), .aresetn(aresetn), .period(period), .trig(trig),
    .busy(busy), .overrun(overrun), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot), .rvalid(rvalid), .rready(rready),
    .rresp(rresp), .rdata(rdata), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_err(smp_err)
`ifdef AXI_COUNTER_POLLER_DELTA_EN
    , .smp_delta(smp_delta)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ar_count = 0;
  int ovr_count = 0;
  int rsp_lat = 2;
  int ar_cyc[$];
  logic [65:0] rq[$];
  logic [63:0] auto_data = 64'h100;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        exp_err;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic consume();
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (smp_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (smp_valid !== 1'b1) chk({name, " timeout"}, {63'd0, smp_valid}, 64'd1);
  endtask

  // Responder: handshakes are judged from values held across the edge, recorded 2 units after it.
  initial begin : responder
    int cnt;
    bit ar_was, r_was;
    logic [65:0] e;
    cnt = -1; ar_was = 0; r_was = 0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(posedge clk_dst);
      #2;
      cyc++;
      if (!aresetn) begin
        rvalid = 1'b0;
        cnt = -1;
      end else begin
        if (r_was) rvalid = 1'b0;
        if (overrun) ovr_count++;
        if (ar_was) begin
          ar_count++;
          ar_cyc.push_back(cyc);
          cnt = rsp_lat;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (cnt == 0) begin
          if (rq.size() > 0) e = rq.pop_front();
          else begin
            e = {2'b00, auto_data};
            auto_data += 64'd1;
          end
          rdata = e[63:0];
          rresp = e[65:64];
          rvalid = 1'b1;
          cnt = -1;
        end
      end
      ar_was = aresetn & arvalid & arready;
      r_was  = aresetn & rvalid & rready;
    end
  end

  initial begin
    bit any_high, stable;
    int a0, o0, bad, n;
    logic [63:0] d0;

    tbl[0] = '{data: 64'h0000_0000_0000_1234, resp: 2'b00, exp_err: 1'b0};
    tbl[1] = '{data: 64'hDEAD_BEEF_0000_0001, resp: 2'b10, exp_err: 1'b1};
    tbl[2] = '{data: 64'h0000_0000_0000_0042, resp: 2'b00, exp_err: 1'b0};
    tbl[3] = '{data: 64'hFFFF_FFFF_FFFF_FFFF, resp: 2'b11, exp_err: 1'b1};
    tbl[4] = '{data: 64'h0000_0000_0000_0000, resp: 2'b01, exp_err: 1'b1};
    tbl[5] = '{data: 64'h8000_0000_0000_0000, resp: 2'b00, exp_err: 1'b0};

    aresetn = 1'b0; period = '0; trig = 1'b0; arready = 1'b1; smp_ready = 1'b0;
    repeat (3) step();
    chk("reset ctl outputs", {59'd0, arvalid, rready, smp_valid, busy, overrun}, 64'd0);
    chk("reset smp_data", smp_data, 64'd0);
    chk("reset smp_err", {63'd0, smp_err}, 64'd0);
    chk("araddr", {52'd0, araddr}, {52'd0, P_ADDR});
    chk("arprot", {61'd0, arprot}, {61'd0, P_PROT});

    // Quiet for 100 cycles with period 0 and no trigger.
    aresetn = 1'b1;
    any_high = 0;
    repeat (100) begin
      step();
      if ({arvalid, rready, smp_valid, busy, overrun} != 5'd0) any_high = 1;
    end
    chk("idle 100 cycles", {63'd0, any_high}, 64'd0);

    // Trigger latency and arvalid held while arready is low.
    arready = 1'b0;
    rq.push_back({2'b00, 64'h1234});
    pulse_trig();
    chk("arvalid at T+1", {63'd0, arvalid}, 64'd0);
    step();
    chk("arvalid at T+2", {63'd0, arvalid}, 64'd1);
    chk("busy in ADDR", {63'd0, busy}, 64'd1);
    step(); step();
    chk("arvalid held", {63'd0, arvalid}, 64'd1);
    arready = 1'b1;
    step();
    chk("DATA phase arvalid/rready", {62'd0, arvalid, rready}, 64'd1);
    wait_valid("first sample");
    chk("first smp_data", smp_data, 64'h1234);
    chk("first smp_err", {63'd0, smp_err}, 64'd0);
    chk("single AR", ar_count, 64'd1);
    consume();
    chk("busy after consume", {63'd0, busy}, 64'd0);

    // Table of responses, including error responses followed by OKAY.
    for (int i = 0; i < 6; i++) begin
      rq.push_back({tbl[i].resp, tbl[i].data});
      pulse_trig();
      wait_valid($sformatf("vec%0d", i));
      chk($sformatf("vec%0d data", i), smp_data, tbl[i].data);
      chk($sformatf("vec%0d err", i), {63'd0, smp_err}, {63'd0, tbl[i].exp_err});
      consume();
      chk($sformatf("vec%0d busy", i), {63'd0, busy}, 64'd0);
    end

    // One request queues during a transaction; a second is dropped with an overrun pulse.
    a0 = ar_count;
    arready = 1'b0;
    pulse_trig();
    step();
    trig = 1'b1; step(); trig = 1'b0;
    chk("queued trig no overrun", {63'd0, overrun}, 64'd0);
    trig = 1'b1; step(); trig = 1'b0;
    chk("dropped trig overrun", {63'd0, overrun}, 64'd1);
    step();
    chk("overrun one cycle", {63'd0, overrun}, 64'd0);
    arready = 1'b1;
    wait_valid("ovr sample 1");
    consume();
    chk("queued read issued", {63'd0, busy}, 64'd1);
    wait_valid("ovr sample 2");
    consume();
    step();
    chk("idle after queue", {63'd0, busy}, 64'd0);
    chk("two ARs for overrun seq", ar_count - a0, 64'd2);

    // Reset in the middle of the address phase abandons the read.
    arready = 1'b0;
    pulse_trig();
    step();
    chk("arvalid before mid reset", {63'd0, arvalid}, 64'd1);
    aresetn = 1'b0;
    step();
    chk("mid reset outputs", {62'd0, arvalid, busy}, 64'd0);
    aresetn = 1'b1;
    arready = 1'b1;
    repeat (5) step();
    chk("idle after mid reset", {62'd0, busy, arvalid}, 64'd0);

    // Periodic sampling every 50 cycles with an 8-cycle responder.
    rsp_lat = 8;
    smp_ready = 1'b1;
    ar_cyc.delete();
    o0 = ovr_count;
    period = 32'd50;
    n = 0;
    while (ar_cyc.size() < 11 && n < 800) begin
      step();
      n++;
    end
    chk("periodic AR count", {63'd0, ar_cyc.size() >= 11}, 64'd1);
    bad = 0;
    for (int i = 1; i < ar_cyc.size(); i++) if (ar_cyc[i] - ar_cyc[i-1] != 50) bad++;
    chk("period 50 spacing", bad, 64'd0);
    chk("periodic no overrun", ovr_count - o0, 64'd0);
    period = '0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("periodic drained", {63'd0, busy}, 64'd0);
    rsp_lat = 2;
    smp_ready = 1'b0;

    // Sample stalled for 200 cycles with period 20.
    period = 32'd20;
    wait_valid("bp first");
    a0 = ar_count;
    o0 = ovr_count;
    d0 = smp_data;
    stable = 1;
    repeat (200) begin
      step();
      if (smp_valid !== 1'b1 || smp_data !== d0) stable = 0;
    end
    chk("bp sample stable", {63'd0, stable}, 64'd1);
    chk("bp no AR while stalled", ar_count - a0, 64'd0);
    chk("bp overrun seen", {63'd0, (ovr_count - o0) > 0}, 64'd1);
    period = '0;
    step();
    consume();
    wait_valid("bp queued");
    chk("bp one queued AR", ar_count - a0, 64'd1);
    consume();
    repeat (3) step();
    chk("bp idle after release", {63'd0, busy}, 64'd0);
    chk("bp still one AR", ar_count - a0, 64'd1);

`ifdef AXI_COUNTER_POLLER_DELTA_EN
    // Delta across a 64-bit wrap, starting from a fresh reset.
    aresetn = 1'b0;
    step(); step();
    aresetn = 1'b1;
    rq.push_back({2'b00, 64'hFFFF_FFFF_FFFF_FFF0});
    rq.push_back({2'b00, 64'h0000_0000_0000_0010});
    pulse_trig();
    wait_valid("delta 1");
    chk("delta first", smp_delta, 64'd0);
    consume();
    pulse_trig();
    wait_valid("delta 2");
    chk("delta data", smp_data, 64'h10);
    chk("delta wrap", smp_delta, 64'h20);
    consume();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
